// File: rtl/pattern_detector_pkg.sv
// Shared types and parameter checks for the serial pattern detector.
package pattern_detector_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } pd_state_t;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 32;
  localparam int CNT_W_MIN   = 1;
  localparam int CNT_W_MAX   = 32;

  function automatic bit params_legal(input int pat_len, input int cnt_w);
    return (pat_len >= PAT_LEN_MIN) && (pat_len <= PAT_LEN_MAX) &&
           (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
  endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter: holds at all-ones, flags saturation in the same cycle.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] count_nxt;

  // next count: step unless already at the ceiling
  always_comb begin
    count_nxt = count;
    if (inc && (count != MAX)) begin
      count_nxt = count + WIDTH'(1);
    end
  end

  // count and sat registered from the same next value so they never disagree
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      sat   <= (count_nxt == MAX);
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with optional overlapping matches.
//
// state | meaning
// FILL  | fewer than PAT_LEN bits collected since reset/clear/last non-overlap hit
// ARMED | PAT_LEN bits held; every accepted bit is compared against pattern
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap_en,
  input  logic               clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               armed
);

  if (!params_legal(PAT_LEN, CNT_W)) begin : g_param_check
    $error("pattern_detector: PAT_LEN or CNT_W out of range");
  end

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  pd_state_t            state, state_nxt;
  // only the youngest PAT_LEN-1 bits are ever needed to form the next window
  logic [PAT_LEN-2:0]   shift_reg, shift_nxt;
  logic [FILL_W-1:0]    fill_cnt, fill_nxt, fill_plus;
  logic [PAT_LEN-1:0]   window;
  logic                 accept, full, hit;

  // next-state, shift/fill update and hit detection
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    fill_nxt  = fill_cnt;
    accept    = din_valid & ~clear;
    window    = {shift_reg, din};
    fill_plus = fill_cnt + FILL_W'(1);
    full      = (state == ARMED) || (fill_plus == FILL_W'(PAT_LEN));
    hit       = accept && full && (window == pattern);

    if (accept) begin
      shift_nxt = window[PAT_LEN-2:0];
      if (state == FILL) begin
        fill_nxt = fill_plus;
        if (full) begin
          state_nxt = ARMED;
        end
      end
      // non-overlapping: the matched bits are consumed, refill from scratch
      if (hit && !overlap_en) begin
        state_nxt = FILL;
        fill_nxt  = '0;
        shift_nxt = '0;
      end
    end
  end

  // state, history and match pulse registers; clear acts like reset
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= FILL;
      shift_reg <= '0;
      fill_cnt  <= '0;
      match     <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      fill_cnt  <= fill_nxt;
      match     <= hit;
    end
  end

  assign armed = (state == ARMED);

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_sat_counter (
    .clk  (clk),
    .inc  (hit),
    .clr  (reset | clear),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: directed scenarios plus random traffic against a
// history-queue reference model. Two instances share stimulus: CNT_W=8 and CNT_W=2.
module tb_pattern_detector;

  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          din_valid = 1'b0;
  logic          din = 1'b0;
  logic [PL-1:0] pattern = 4'b1011;
  logic          overlap_en = 1'b1;
  logic          clear = 1'b0;

  logic       m8, sat8, arm8;
  logic [7:0] cnt8;
  logic       m2, sat2, arm2;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  bit hist[$];
  int exp_cnt8 = 0;
  int exp_cnt2 = 0;
  bit exp_match = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  pattern_detector #(.PAT_LEN(PL), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .pattern(pattern), .overlap_en(overlap_en), .clear(clear),
    .match(m8), .match_count(cnt8), .count_sat(sat8), .armed(arm8)
  );

  pattern_detector #(.PAT_LEN(PL), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .pattern(pattern), .overlap_en(overlap_en), .clear(clear),
    .match(m2), .match_count(cnt2), .count_sat(sat2), .armed(arm2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference: bits accepted since the last restart; a hit is the newest
  // PL of them spelling the pattern, a non-overlap hit empties the history
  task automatic model_update(input bit v, input bit d, input bit c, input bit r);
    logic [PL-1:0] val;
    exp_match = 0;
    if (r || c) begin
      hist.delete();
      exp_cnt8 = 0;
      exp_cnt2 = 0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > PL) void'(hist.pop_front());
      if (hist.size() == PL) begin
        val = '0;
        for (int i = 0; i < PL; i++) val = {val[PL-2:0], hist[i]};
        if (val == pattern) begin
          exp_match = 1;
          if (exp_cnt8 < 255) exp_cnt8++;
          if (exp_cnt2 < 3) exp_cnt2++;
          if (!overlap_en) hist.delete();
        end
      end
    end
  endtask

  task automatic step(input bit v, input bit d, input bit c, input bit r);
    din_valid = v;
    din = d;
    clear = c;
    reset = r;
    @(posedge clk);
    model_update(v, d, c, r);
    #1;
    pulses += int'(m8);
    check_val("match8", m8, exp_match);
    check_val("match2", m2, exp_match);
    check_val("count8", cnt8, exp_cnt8);
    check_val("count2", cnt2, exp_cnt2);
    check_val("sat8", sat8, exp_cnt8 == 255);
    check_val("sat2", sat2, exp_cnt2 == 3);
    check_val("armed8", arm8, hist.size() == PL);
    check_val("armed2", arm2, hist.size() == PL);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, bits[i], 0, 0);
  endtask

  initial begin
    // reset held two cycles
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check_val("rst_match", m8, 0);
    check_val("rst_count", cnt8, 0);
    check_val("rst_armed", arm8, 0);

    // 1,0,1,1 -> one match, armed
    pattern = 4'b1011;
    overlap_en = 1;
    pulses = 0;
    send_bits(8'b1011, 4);
    check_val("s036_armed", arm8, 1);
    check_val("s036_match", m8, 1);
    check_val("s036_count", cnt8, 1);
    step(0, 0, 0, 0);
    check_val("s036_pulse_end", m8, 0);

    // overlapping stream
    step(0, 0, 0, 1);
    pulses = 0;
    send_bits(8'b1011011, 7);
    check_val("s037_pulses", pulses, 2);
    check_val("s037_count", cnt8, 2);

    // non-overlapping stream
    step(0, 0, 0, 1);
    overlap_en = 0;
    pulses = 0;
    send_bits(8'b1011011, 7);
    check_val("s038_pulses", pulses, 1);
    check_val("s038_count", cnt8, 1);
    check_val("s038_armed", arm8, 0);

    // gap with din toggling while din_valid is low
    step(0, 0, 0, 1);
    overlap_en = 1;
    pulses = 0;
    send_bits(8'b10, 2);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check_val("s039_gap_count", cnt8, 0);
    send_bits(8'b11, 2);
    check_val("s039_pulses", pulses, 1);
    check_val("s039_count", cnt8, 1);

    // saturation on the narrow counter
    step(0, 0, 0, 1);
    pattern = 4'b1111;
    pulses = 0;
    send_bits(8'b11111111, 8);
    check_val("s040_pulses", pulses, 5);
    check_val("s040_count2", cnt2, 3);
    check_val("s040_sat2", sat2, 1);
    check_val("s040_count8", cnt8, 5);

    // clear with simultaneous valid bit
    step(0, 0, 0, 1);
    pattern = 4'b1011;
    send_bits(8'b101, 3);
    step(1, 1, 1, 0);
    check_val("s041_match", m8, 0);
    check_val("s041_count", cnt8, 0);
    check_val("s041_armed", arm8, 0);
    pulses = 0;
    send_bits(8'b1011, 4);
    check_val("s041_pulses", pulses, 1);

    // reset overrides clear and a valid bit
    send_bits(8'b101, 3);
    step(1, 1, 1, 1);
    send_bits(8'b1, 1);
    check_val("rst_mid_armed", arm8, 0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) pattern = PL'($urandom);
      if ($urandom_range(0, 99) == 0) overlap_en = ~overlap_en;
      step($urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 149) == 0, $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
